sha256_wsched: RTL and testbench
================================

# sha256_wsched

Message-schedule stage of the SHA-256 round pipeline. Accepts one 512-bit padded message block and streams the 64 schedule words W[0..63], each paired with its round constant K[t], one word per handshake. Sits directly upstream of the round datapath: the round logic consumes w_out/k_out (as wr/kr) to form the agwk term fed to the efgh stage. Uses a 16-word sliding window, so block memory is 512 bits regardless of round count.

## Interface
- No parameters. Word width is fixed at 32 and round count at 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- blk_valid  in  1  blk_data holds a block to load.
- blk_ready  out  1  stage can accept a block this cycle.
- blk_data  in  512  padded block; word 0 = blk_data[511:480], big-endian word order.
- w_valid  out  1  w_out/k_out/w_idx/w_last valid.
- w_ready  in  1  downstream accepts current word.
- w_out  out  32  schedule word W[t].
- k_out  out  32  round constant K[t].
- w_idx  out  6  round index t.
- w_last  out  1  high when t == 63.

## Operation
- State: IDLE, RUN. Registers: win[0..15] (32b each), cnt (6b), output registers.
- blk_ready = rst_n && (state==IDLE || (w_valid && w_ready && w_last)). This is combinational on w_ready.
- Load, when blk_valid && blk_ready:
  - win[i] = blk_data[511-32i -: 32].
  - cnt = 0; state = RUN.
  - Next cycle: w_out=win[0], k_out=K[0], w_idx=0, w_valid=1.
- RUN, on w_valid && w_ready with cnt<63:
  - win shifts down one (win[i]=win[i+1]).
  - win[15] = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - cnt++; outputs update to the new win[0] and K[cnt].
- σ0(x) = ror7 ^ ror18 ^ shr3. σ1(x) = ror17 ^ ror19 ^ shr10.
- Words 0..15 pass through unchanged; words 16..63 are computed by the recurrence.
- RUN, on handshake with cnt==63:
  - If a new block is loaded in the same cycle (blk_valid=1), go straight to the load behaviour with no bubble.
  - Otherwise state=IDLE and w_valid=0 next cycle.
- Stall: while w_valid && !w_ready, all outputs and the window hold stable.
- blk_valid is ignored while blk_ready=0. blk_data is sampled only on a load handshake.
- K table: the 64 standard SHA-256 constants, held in a constant ROM indexed by cnt.

## Timing
- Reset, when rst_n=0 at an edge:
  - state=IDLE, cnt=0, win all zero.
  - w_valid=0, w_out=0, k_out=0, w_idx=0, w_last=0.
  - blk_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-block: the block is abandoned and no further w_valid is asserted. A new block is accepted normally after release.
- Latency: block accepted at edge N gives W[0] valid after edge N (cycle N+1).
- Throughput: with w_ready held high and back-to-back blocks, 64 words per 64 cycles, with no gap between W[63] and the next W[0].
- w_last is asserted together with w_valid for t=63 only.
- Exactly 64 handshakes per loaded block, never more or fewer.

## Test plan
- "abc" block (61626380, then 14 zero words, then 00000018), w_ready=1:
  - W[0]=61626380, W[15]=00000018, W[16]=61626380, W[17]=000F0000.
  - K[0]=428a2f98, K[63]=c67178f2.
  - w_last is high only at idx 63.
  - All 64 words match the reference model.
- All-zero block: all 64 W are 00000000; k_out follows the K table; 64 handshakes, then w_valid=0 and blk_ready=1.
- Random w_ready stalls (about 50%) on a random block: outputs are held during each stall, and the W sequence is identical to the no-stall run.
- Two blocks back-to-back with blk_valid=1 throughout:
  - blk_ready pulses in the W[63] handshake cycle.
  - The second block's W[0] appears in the next cycle (128 words in 128 cycles).
- rst_n=0 during t=30:
  - The next cycle shows w_valid=0 and all outputs 0.
  - After release, a new "abc" block streams correctly from W[0].
- blk_valid asserted during RUN (not at t=63): the block is not accepted and blk_ready stays 0 until the t=63 handshake.

Source files
------------

// File: rtl/sha256_wsched_if.sv
// Handshake bundle between the block source, the schedule stage and the round datapath.
interface sha256_wsched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [5:0]   w_idx;
  logic         w_last;

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_out, k_out, w_idx, w_last
  );

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_out, k_out, w_idx, w_last
  );
endinterface

// File: rtl/sha256_wsched.sv
// SHA-256 message schedule: streams W[0..63] with K[t] from a 16-word sliding window.
module sha256_wsched (
  input  logic           clk,
  input  logic           rst_n,
  sha256_wsched_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e              state_q, state_d;
  // Ascending index so win[0] lines up with blk_data[511:480].
  logic [0:15][31:0]   win_q, win_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                w_valid_q, w_valid_d;
  logic [31:0]         w_out_q, w_out_d;
  logic [31:0]         k_out_q, k_out_d;
  logic [5:0]          w_idx_q, w_idx_d;
  logic                w_last_q, w_last_d;

  logic                hs, load;
  logic [31:0]         w_new;

  assign hs            = w_valid_q && bus.w_ready;
  assign bus.blk_ready = rst_n && (state_q == IDLE || (hs && w_last_q));
  assign load          = bus.blk_valid && bus.blk_ready;
  assign w_new         = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    w_valid_d = w_valid_q;
    w_out_d   = w_out_q;
    k_out_d   = k_out_q;
    w_idx_d   = w_idx_q;
    w_last_d  = w_last_q;
    if (load) begin
      // Also covers the t==63 handshake, so back-to-back blocks have no bubble.
      state_d   = RUN;
      win_d     = bus.blk_data;
      cnt_d     = '0;
      w_valid_d = 1'b1;
      w_out_d   = bus.blk_data[511:480];
      k_out_d   = K[0];
      w_idx_d   = '0;
      w_last_d  = 1'b0;
    end else if (state_q == RUN && hs) begin
      if (cnt_q == 6'd63) begin
        state_d   = IDLE;
        w_valid_d = 1'b0;
        w_last_d  = 1'b0;
      end else begin
        win_d    = {win_q[1:15], w_new};
        cnt_d    = cnt_q + 6'd1;
        w_out_d  = win_q[1];
        k_out_d  = K[cnt_q + 6'd1];
        w_idx_d  = cnt_q + 6'd1;
        w_last_d = (cnt_q == 6'd62);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      cnt_q     <= '0;
      w_valid_q <= 1'b0;
      w_out_q   <= '0;
      k_out_q   <= '0;
      w_idx_q   <= '0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      w_valid_q <= w_valid_d;
      w_out_q   <= w_out_d;
      k_out_q   <= k_out_d;
      w_idx_q   <= w_idx_d;
      w_last_q  <= w_last_d;
    end
  end

  assign bus.w_valid = w_valid_q;
  assign bus.w_out   = w_out_q;
  assign bus.k_out   = k_out_q;
  assign bus.w_idx   = w_idx_q;
  assign bus.w_last  = w_last_q;
endmodule

// File: tb/tb_sha256_wsched.sv
// Directed bench for sha256_wsched: abc/zero/random blocks, stalls, back-to-back, reset, early blk_valid.
module tb_sha256_wsched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_wsched_if bus();
  sha256_wsched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_w [64];
  logic [31:0] exp_a [64];
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];
  logic [5:0]  got_idx [64];
  logic        got_last [64];
  int          got_n, stall_bad, last_cnt, col_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic build_ref(input logic [511:0] b);
    for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  function automatic int mism();
    int m = 0;
    for (int t = 0; t < 64; t++) begin
      if (got_w[t] !== exp_w[t]) m++;
      if (got_k[t] !== KT[t]) m++;
      if (got_idx[t] !== 6'(t)) m++;
      if (got_last[t] !== (t == 63)) m++;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_blk(input logic [511:0] b, input string tag);
    int k = 0;
    bus.blk_data  = b;
    bus.blk_valid = 1'b1;
    #1;
    while (!bus.blk_ready && k < 200) begin step(); k++; end
    chk({tag, "_accept"}, bus.blk_ready, 1);
    step();
    bus.blk_valid = 1'b0;
  endtask

  task automatic collect(input int stall_pct);
    int cyc = 0;
    bit prev_stall = 0;
    logic [31:0] hw = '0, hk = '0;
    logic [5:0]  hi = '0;
    logic        hl = 1'b0;
    got_n = 0; stall_bad = 0; last_cnt = 0;
    while (got_n < 64 && cyc < 1000) begin
      if (prev_stall && (bus.w_valid !== 1'b1 || bus.w_out !== hw || bus.k_out !== hk ||
                         bus.w_idx !== hi || bus.w_last !== hl)) stall_bad++;
      bus.w_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
      #1;
      if (bus.w_valid && bus.w_ready) begin
        got_w[got_n]    = bus.w_out;
        got_k[got_n]    = bus.k_out;
        got_idx[got_n]  = bus.w_idx;
        got_last[got_n] = bus.w_last;
        if (bus.w_last) last_cnt++;
        got_n++;
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      hw = bus.w_out; hk = bus.k_out; hi = bus.w_idx; hl = bus.w_last;
      step();
      cyc++;
    end
    bus.w_ready = 1'b1;
    col_cyc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, rb, ra;
    int k, vcnt, rcnt, bad, early, hsn;
    logic rdy63;
    bit done;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.w_ready   = 1'b1;
    rst_n = 1'b0;
    step(); step();

    // Reset state
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_w_out", bus.w_out, 0);
    chk("rst_k_out", bus.k_out, 0);
    chk("rst_w_idx", bus.w_idx, 0);
    chk("rst_w_last", bus.w_last, 0);
    chk("rst_blk_ready", bus.blk_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_blk_ready", bus.blk_ready, 1);

    // "abc" block, no stalls
    build_ref(abc);
    load_blk(abc, "abc");
    chk("abc_first_valid", bus.w_valid, 1);
    chk("abc_first_idx", bus.w_idx, 0);
    collect(0);
    chk("abc_count", got_n, 64);
    chk("abc_cycles", col_cyc, 64);
    chk("abc_w0", got_w[0], 32'h61626380);
    chk("abc_w15", got_w[15], 32'h00000018);
    chk("abc_w16", got_w[16], 32'h61626380);
    chk("abc_w17", got_w[17], 32'h000f0000);
    chk("abc_k0", got_k[0], 32'h428a2f98);
    chk("abc_k63", got_k[63], 32'hc67178f2);
    chk("abc_last_cnt", last_cnt, 1);
    chk("abc_last63", got_last[63], 1);
    chk("abc_model_mism", mism(), 0);
    chk("abc_end_valid", bus.w_valid, 0);
    chk("abc_end_ready", bus.blk_ready, 1);

    // All-zero block
    build_ref('0);
    load_blk('0, "zero");
    collect(0);
    chk("zero_count", got_n, 64);
    chk("zero_w40", got_w[40], 0);
    chk("zero_model_mism", mism(), 0);
    chk("zero_end_valid", bus.w_valid, 0);
    chk("zero_end_ready", bus.blk_ready, 1);

    // Random block with ~50% w_ready stalls
    for (int i = 0; i < 16; i++) rb[511-32*i -: 32] = $urandom();
    build_ref(rb);
    load_blk(rb, "stall");
    collect(50);
    chk("stall_count", got_n, 64);
    chk("stall_held", stall_bad, 0);
    chk("stall_had_stalls", col_cyc > 64, 1);
    chk("stall_model_mism", mism(), 0);

    // Back-to-back blocks, random then abc
    for (int i = 0; i < 16; i++) ra[511-32*i -: 32] = $urandom();
    build_ref(ra);
    exp_a = exp_w;
    build_ref(abc);
    bus.blk_data  = ra;
    bus.blk_valid = 1'b1;
    #1;
    chk("b2b_ready0", bus.blk_ready, 1);
    step();
    bus.blk_data = abc;
    vcnt = 0; rcnt = 0; bad = 0; rdy63 = 1'b0;
    for (int c = 0; c < 128; c++) begin
      if (c == 64) bus.blk_valid = 1'b0;
      #1;
      if (bus.w_valid) vcnt++;
      if (bus.blk_ready) rcnt++;
      if (c == 63) rdy63 = bus.blk_ready;
      if (c < 64) begin
        if (bus.w_out !== exp_a[c]) bad++;
      end else if (bus.w_out !== exp_w[c-64]) bad++;
      step();
    end
    chk("b2b_valid_cycles", vcnt, 128);
    chk("b2b_ready_pulses", rcnt, 2);
    chk("b2b_ready_at63", rdy63, 1);
    chk("b2b_word_mism", bad, 0);
    chk("b2b_end_valid", bus.w_valid, 0);

    // Reset during t=30
    load_blk(abc, "rstmid");
    k = 0;
    while (bus.w_idx != 6'd30 && k < 100) begin step(); k++; end
    chk("rstmid_reach30", bus.w_idx, 30);
    rst_n = 1'b0;
    step();
    chk("rstmid_valid", bus.w_valid, 0);
    chk("rstmid_w_out", bus.w_out, 0);
    chk("rstmid_k_out", bus.k_out, 0);
    chk("rstmid_idx", bus.w_idx, 0);
    chk("rstmid_last", bus.w_last, 0);
    rst_n = 1'b1;
    #1;
    chk("rstmid_rel_ready", bus.blk_ready, 1);
    step();
    chk("rstmid_no_valid", bus.w_valid, 0);
    load_blk(abc, "rstabc");
    collect(0);
    chk("rstabc_count", got_n, 64);
    chk("rstabc_model_mism", mism(), 0);

    // blk_valid raised mid-run is held off until the t=63 handshake
    load_blk('0, "early");
    early = 0; hsn = 0; k = 0; done = 0;
    while (!done && k < 200) begin
      if (k == 10) begin bus.blk_data = abc; bus.blk_valid = 1'b1; end
      #1;
      if (bus.blk_ready && !(bus.w_valid && bus.w_last)) early++;
      if (bus.w_valid && bus.w_ready) begin
        hsn++;
        if (bus.w_last) done = 1;
      end
      step();
      k++;
    end
    bus.blk_valid = 1'b0;
    chk("early_ready_held", early, 0);
    chk("early_handshakes", hsn, 64);
    chk("early_next_w0", bus.w_out, 32'h61626380);
    chk("early_next_idx", bus.w_idx, 0);
    build_ref(abc);
    collect(0);
    chk("early_abc_mism", mism(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
